// File: rtl/number_state_pkg.sv
// -----------------------------------------------------------------------------
// number_state_pkg
//
// Shared types and constants for the push-button decimal counter that drives
// the seven-segment board driver's `number` bus.
//
// Contents:
//   NUMBER_W             width of the `number` bus
//   DEF_DEBOUNCE_CYCLES  default debounce window (10 ms at 100 MHz)
//   DEF_TICK_CYCLES      default automatic step period (10 Hz at 100 MHz)
//   DEF_MAX_VALUE        default largest displayed value (eight decimal digits)
//   run_state_t          counter mode: paused, running up, running down
//   number_t             value type carried on the `number` bus
//   wrap_step()          +1/-1 step that wraps between 0 and a maximum
// -----------------------------------------------------------------------------
package number_state_pkg;

    localparam int NUMBER_W = 32;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_TICK_CYCLES     = 10_000_000;
    localparam int unsigned DEF_MAX_VALUE       = 99_999_999;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } run_state_t;

    typedef logic [NUMBER_W-1:0] number_t;

    // One counting step in either direction. Values above max_value can never
    // be produced, so the counter stays inside 0..max_value from reset onward.
    function automatic number_t wrap_step(input number_t value,
                                          input logic    down,
                                          input number_t max_value);
        number_t result;
        if (down) begin
            result = (value == '0) ? max_value : value - NUMBER_W'(1);
        end else begin
            result = (value >= max_value) ? '0 : value + NUMBER_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Cleans one raw push-button input into a stable level and a one-cycle press
// pulse on each accepted rising edge of that level.
//
// Ports:
//   CLK100MHZ  in   system clock
//   RESET      in   synchronous, active-high reset
//   raw        in   asynchronous button input straight from the board pin
//   level      out  debounced button level
//   press      out  one-cycle pulse, DEBOUNCE_CYCLES+3 cycles after a clean
//                   raw 0->1 transition
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to flip `level`
// -----------------------------------------------------------------------------
module button_debounce
    import number_state_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK100MHZ,
    input  logic RESET,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;
    logic             level_d;

    // NOTE: every register here is written with non-blocking assignments so
    // each flop samples the pre-edge value of its neighbour; blocking
    // assignments would collapse the synchronizer chain into a single stage.
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            press      <= 1'b0;
        end else begin
            // Two flops before any logic looks at the pin.
            sync_q1 <= raw;
            sync_q2 <= sync_q1;

            // The level moves only after an unbroken run of disagreeing
            // samples; a single agreeing sample restarts the run.
            if (sync_q2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_q2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end

            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/number_state.sv
// -----------------------------------------------------------------------------
// number_state
//
// Manual / automatic decimal up-down counter controlled by the four Nexys
// push-buttons. Its `number` output feeds the seven-segment board driver.
//
// Ports:
//   CLK100MHZ  in   system clock, 100 MHz
//   RESET      in   synchronous, active-high reset
//   BTNU       in   raw button: increment (paused) / run upward (running)
//   BTND       in   raw button: decrement (paused) / run downward (running)
//   BTNC       in   raw button: toggle run / pause
//   BTNL       in   raw button: clear count and restart the tick period
//   number     out  current count, always 0..MAX_VALUE
//   LED        out  LED[0] = running, LED[1] = running downward
//
// Parameters:
//   DEBOUNCE_CYCLES  button debounce window in clock cycles
//   TICK_CYCLES      clock cycles per automatic step while running
//   MAX_VALUE        largest count; stepping wraps between 0 and MAX_VALUE
//
// Button priority when press pulses coincide: BTNL > BTNC > BTNU > BTND.
// Any acting button suppresses an automatic step landing in the same cycle.
// -----------------------------------------------------------------------------
module number_state
    import number_state_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int unsigned MAX_VALUE       = DEF_MAX_VALUE
) (
    input  logic                CLK100MHZ,
    input  logic                RESET,
    input  logic                BTNU,
    input  logic                BTND,
    input  logic                BTNC,
    input  logic                BTNL,
    output logic [NUMBER_W-1:0] number,
    output logic [1:0]          LED
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam number_t           MAX_NUM   = NUMBER_W'(MAX_VALUE);

    // -------------------------------------------------------------------------
    // Button conditioning
    // -------------------------------------------------------------------------
    logic press_u;
    logic press_d;
    logic press_c;
    logic press_l;

    // Debounced levels are available from each debouncer but only the press
    // pulses drive this block.
    logic [3:0] btn_level_unused;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .raw       (BTNU),
        .level     (btn_level_unused[0]),
        .press     (press_u)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_d (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .raw       (BTND),
        .level     (btn_level_unused[1]),
        .press     (press_d)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .raw       (BTNC),
        .level     (btn_level_unused[2]),
        .press     (press_c)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .raw       (BTNL),
        .level     (btn_level_unused[3]),
        .press     (press_l)
    );

    // -------------------------------------------------------------------------
    // Counter state machine
    // -------------------------------------------------------------------------
    run_state_t        state_q;
    run_state_t        state_d;
    number_t           number_q;
    number_t           number_d;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    logic running;
    logic tick_hit;

    assign running  = (state_q != PAUSED);
    assign tick_hit = running && (tick_q == TICK_LAST);

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        tick_d   = '0;

        // Free-running period while running; the wrap happens even when a
        // button steals the step from this cycle.
        if (running) begin
            tick_d = tick_hit ? '0 : tick_q + TICK_W'(1);
        end

        if (press_l) begin
            number_d = '0;
            tick_d   = '0;
        end else if (press_c) begin
            // Entering a run starts a full period; leaving parks the counter.
            state_d = running ? PAUSED : RUN_UP;
            tick_d  = '0;
        end else if (press_u) begin
            if (running) begin
                state_d = RUN_UP;
            end else begin
                number_d = wrap_step(number_q, 1'b0, MAX_NUM);
            end
        end else if (press_d) begin
            if (running) begin
                state_d = RUN_DOWN;
            end else begin
                number_d = wrap_step(number_q, 1'b1, MAX_NUM);
            end
        end else if (tick_hit) begin
            number_d = wrap_step(number_q, state_q == RUN_DOWN, MAX_NUM);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            state_q  <= PAUSED;
            number_q <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            tick_q   <= tick_d;
        end
    end

    assign number = number_q;
    assign LED    = {state_q == RUN_DOWN, running};

endmodule
